// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the ALU family.
package alu_pkg;

  localparam logic [5:0] OP_AND = 6'd36;
  localparam logic [5:0] OP_OR  = 6'd37;
  localparam logic [5:0] OP_ADD = 6'd32;
  localparam logic [5:0] OP_SUB = 6'd34;
  localparam logic [5:0] OP_SLT = 6'd42;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_valid_op(input logic [5:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU slice: AND/OR/ADD/SUB/SLT selected by the shared Signal codes.
module alu_1bit
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       less,
  input  logic       cin,
  input  logic [5:0] signal,
  output logic       sum,
  output logic       cout
);

  logic b_inv;

  always_comb begin
    sum   = 1'b0;
    cout  = 1'b0;
    b_inv = ~b;
    case (signal)
      OP_AND: sum = a & b;
      OP_OR:  sum = a | b;
      OP_ADD: begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
      OP_SUB: begin
        sum  = a ^ b_inv ^ cin;
        cout = (a & b_inv) | (a & cin) | (b_inv & cin);
      end
      OP_SLT: begin
        sum  = less;
        cout = (a & b_inv) | (a & cin) | (b_inv & cin);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU: one alu_1bit slice reused over WIDTH cycles, LSB first.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [5:0]       op_q, slice_op;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, err_q;
  logic             slice_sum, slice_cout, last_bit;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  // SLT runs as a plain subtraction; its fix-up pass reads the sign afterwards.
  assign slice_op = (op_q == OP_SLT) ? OP_SUB : op_q;

  alu_1bit u_slice (
    .a      (a_q[cnt_q]),
    .b      (b_q[cnt_q]),
    .less   (1'b0),
    .cin    (carry_q),
    .signal (slice_op),
    .sum    (slice_sum),
    .cout   (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = is_valid_op(Signal) ? RUN : DONE;
      RUN:  if (last_bit) state_nxt = (op_q == OP_SLT) ? FIX : DONE;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q      <= A;
          b_q      <= B;
          op_q     <= Signal;
          carry_q  <= Signal[1];
          cnt_q    <= '0;
          result_q <= '0;
          cout_q   <= 1'b0;
          err_q    <= !is_valid_op(Signal);
        end
        RUN: begin
          result_q <= {slice_sum, result_q[WIDTH-1:1]};
          carry_q  <= slice_cout;
          cnt_q    <= cnt_q + 1'b1;
          if (last_bit && op_q != OP_SLT) cout_q <= slice_cout;
        end
        FIX: begin
          result_q <= {{(WIDTH-1){1'b0}}, result_q[WIDTH-1]};
          cout_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign Result = result_q;
  assign Cout   = cout_q;
  assign Zero   = (result_q == '0);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign err    = err_q;

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
Bit-serial sequencer that computes one 32-bit ALU operation by reusing a single alu_1bit slice over WIDTH clock cycles, LSB first. Each cycle it latches the slice's carry and shifts the sum bit into a result register. For SLT it runs a subtraction pass, then a one-cycle fix-up pass. It is the area-minimal alternative to the 32-slice ripple ALU and uses the same Signal function codes.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  operand A, latched on accepted start
B  input  WIDTH  operand B, latched on accepted start
Signal  input  6  function code (AND=36, OR=37, ADD=32, SUB=34, SLT=42), latched on accepted start
Result  output  WIDTH  operation result, held until next accepted start
Cout  output  1  final carry-out (0 for AND/OR/SLT/invalid)
Zero  output  1  Result==0, valid whenever done is high or the block is idle after done
busy  output  1  high from the cycle after an accepted start until the cycle done drops
done  output  1  one-cycle completion pulse
err  output  1  set with done when the latched Signal is not one of the five codes; cleared on next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Asserting rst_n low at any time, including mid-operation, immediately forces state=IDLE, clears Result, Cout, busy, done, err, the bit counter, carry reg and operand regs to 0. Zero then reads 1. No partial result survives reset.
- States: IDLE, RUN, FIX, DONE.
- IDLE: when start=1 at a clock edge, latch A, B and Signal, clear Result, err and Cout, set counter=0, and go to RUN.
  - Carry reg init = latched Signal[1]; this is 1 for SUB/SLT and 0 otherwise.
  - Invalid code: go directly to DONE with err=1 and Result=0.
- RUN: slice inputs are A[cnt], B[cnt] and the carry reg, with Less=0.
  - Signal driven to the slice is the latched code, except SLT, which is driven as SUB.
  - Each edge: shift the slice Sum into Result (right-shift, insert at MSB), carry reg <= slice Cout, cnt <= cnt+1.
  - After the edge that processes cnt=WIDTH-1: go to FIX if SLT, otherwise go to DONE and set Cout=slice Cout.
- FIX (SLT only, 1 cycle): Result <= {WIDTH-1 zeros, set}, where set = MSB of the subtraction sum. There is no overflow correction, which matches the textbook ripple ALU. Cout=0. Go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy is high in RUN, FIX and DONE.
- Latency, measured from the accepting edge: done is high in cycle WIDTH+1 for AND/OR/ADD/SUB, WIDTH+2 for SLT, and 1 for invalid codes.
- start while busy is ignored; it is not queued. start high in the DONE cycle is also ignored. start held continuously yields back-to-back operations separated by one IDLE cycle.
- Operand or Signal changes after acceptance have no effect on the operation in progress.
- Arithmetic is modulo 2^WIDTH. For SUB, Cout=1 means no borrow (A>=B unsigned).

Decomposition:
- Shared package alu_pkg: the five Signal opcode localparams (AND, OR, ADD, SUB, SLT) and the state encoding (IDLE=0, RUN=1, FIX=2, DONE=3).
- One sub-module: the existing alu_1bit slice, instantiated once. The counter, shift register, carry reg and FSM stay in the top.

Test Plan:
- ADD: A=0x0000_0005, B=0x0000_0003, Signal=32 -> done at cycle 33, Result=0x8, Cout=0, Zero=0, err=0.
- SUB with wrap: A=3, B=5, Signal=34 -> Result=0xFFFF_FFFE, Cout=0; then A=5, B=5 -> Result=0, Zero=1, Cout=1.
- AND/OR: A=0xF0F0_1234, B=0x0FF0_FF00 -> AND gives 0x00F0_1200 with Cout=0; OR gives 0xFFF0_FF34.
- SLT: A=-1 (0xFFFF_FFFF), B=1, Signal=42 -> done at cycle 34, Result=1. A=7, B=2 -> Result=0.
- Invalid code and busy: Signal=0x3F -> done plus err at cycle 1, Result=0. Pulsing start with new operands during RUN of an ADD leaves that ADD's result unchanged, and exactly one done pulse is produced.
- Reset mid-op: drop rst_n at cycle 10 of an ADD -> outputs 0 immediately, no done pulse. After release, a fresh ADD 1+1 yields Result=2.
